// File: rtl/param_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add and divide is restoring shift-subtract, one bit per cycle.
// Signed operations work on magnitudes, and the signs are corrected in a final FIX cycle.
module param_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] Output
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t state, next_state;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   op_a, op_b, raw_a;
  logic [2*WIDTH-1:0] acc;
  logic               is_div, is_signed, neg_res, neg_rem, b_zero;

  logic               start_op, start_mthi, start_mtlo;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Request decode: codes 24..27 start an iterative op; MTHI and MTLO are immediate writes.
  always_comb begin
    start_op   = start && (Signal[5:2] == 4'b0110);
    start_mthi = start && (Signal == 6'd17);
    start_mtlo = start && (Signal == 6'd19);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and busy flag. Once an op is accepted, it always runs to FIX.
  always_comb begin
    next_state = state;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_op) next_state = PREP;
      end
      PREP:    next_state = RUN;
      RUN:     if (cnt == LAST_BIT) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Per-bit arithmetic: operand magnitudes, one shift-add step, one restoring-divide step, and the sign fix-up.
  always_comb begin
    mag_a    = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b    = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? op_a : {WIDTH{1'b0}})};
    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, op_b});
    div_diff = div_sh[WIDTH-1:0] - op_b;
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Datapath and architectural registers. HI/LO change only at FIX exit or on MTHI/MTLO, so readers never see partial results.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi        <= '0;
      lo        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      raw_a     <= '0;
      acc       <= '0;
      cnt       <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      b_zero    <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_op) begin
            op_a      <= dataA;
            op_b      <= dataB;
            raw_a     <= dataA;
            is_div    <= Signal[1];
            is_signed <= ~Signal[0];
            b_zero    <= (dataB == '0);
            div_zero  <= 1'b0;
          end else if (start_mthi) begin
            hi <= dataA;
          end else if (start_mtlo) begin
            lo <= dataA;
          end
        end
        PREP: begin
          op_a    <= mag_a;
          op_b    <= mag_b;
          neg_res <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          neg_rem <= is_signed && op_a[WIDTH-1];
          acc     <= is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
          cnt     <= '0;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div)
            acc <= {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
          else
            acc <= {mul_sum, acc[WIDTH-1:1]};
        end
        FIX: begin
          done <= 1'b1;
          if (is_div && b_zero) begin
            hi       <= raw_a;
            lo       <= '1;
            div_zero <= 1'b1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // MFHI/MFLO read mux; any other code reads zero.
  always_comb begin
    Output = '0;
    if (Signal == 6'd16)      Output = hi;
    else if (Signal == 6'd18) Output = lo;
  end

endmodule

// File: tb/tb_param_muldiv_unit.sv
// Bench for param_muldiv_unit. It drives a 32-bit and an 8-bit instance from the same inputs.
// An arithmetic reference model is checked against both instances on every cycle.
// Directed vectors with literal expectations also pin the model itself.
module tb_param_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB;
  logic [5:0]  Signal;
  logic        start;

  logic        busy32, done32, dz32;
  logic [31:0] out32;
  logic        busy8, done8, dz8;
  logic [7:0]  out8;

  int checks   = 0;
  int failures = 0;

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  param_muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .Signal(Signal),
    .start(start), .busy(busy32), .done(done32), .div_zero(dz32), .Output(out32)
  );

  param_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .dataA(dataA[7:0]), .dataB(dataB[7:0]), .Signal(Signal),
    .start(start), .busy(busy8), .done(done8), .div_zero(dz8), .Output(out8)
  );

  // Reference result of one operation, computed with plain 64-bit arithmetic at width w.
  function automatic void model_op(input int w, input logic [5:0] code,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo,
                                   output logic dz);
    logic [63:0] mask, ua, ub, up;
    longint      sa, sb, sp, sq, sr;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = ua[w-1] ? longint'(ua | ~mask) : longint'(ua);
    sb   = ub[w-1] ? longint'(ub | ~mask) : longint'(ub);
    hi   = '0;
    lo   = '0;
    dz   = 1'b0;
    case (code)
      6'd24: begin
        sp = sa * sb;
        up = 64'(sp);
        hi = 32'((up >> w) & mask);
        lo = 32'(up & mask);
      end
      6'd25: begin
        up = ua * ub;
        hi = 32'((up >> w) & mask);
        lo = 32'(up & mask);
      end
      6'd26, 6'd27: begin
        if (ub == 64'd0) begin
          hi = 32'(ua);
          lo = 32'(mask);
          dz = 1'b1;
        end else if (code == 6'd26) begin
          sq = sa / sb;
          sr = sa % sb;
          hi = 32'(64'(sr) & mask);
          lo = 32'(64'(sq) & mask);
        end else begin
          hi = 32'(ua % ub);
          lo = 32'(ua / ub);
        end
      end
      default: ;
    endcase
  endfunction

  // Model state per unit (index 0 = 32-bit, 1 = 8-bit).
  logic [31:0] m_hi[2], m_lo[2], p_hi[2], p_lo[2];
  logic        m_done[2], m_dz[2], p_dz[2];
  int          m_rem[2];
  bit          model_ok = 1'b0;

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_hi[u] = '0; m_lo[u] = '0; p_hi[u] = '0; p_lo[u] = '0;
      m_done[u] = 1'b0; m_dz[u] = 1'b0; p_dz[u] = 1'b0; m_rem[u] = 0;
    end
  end

  // Cycle model: an accepted op keeps the unit busy for w+2 cycles and then commits its precomputed result.
  always @(posedge clk) begin : model
    int w;
    logic [31:0] h, l, mask;
    logic z;
    if (reset) begin
      model_ok <= 1'b1;
      for (int u = 0; u < 2; u++) begin
        m_hi[u] <= '0; m_lo[u] <= '0; m_done[u] <= 1'b0; m_dz[u] <= 1'b0; m_rem[u] <= 0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        w    = (u == 0) ? 32 : 8;
        mask = (u == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        m_done[u] <= 1'b0;
        if (m_rem[u] > 0) begin
          m_rem[u] <= m_rem[u] - 1;
          if (m_rem[u] == 1) begin
            m_hi[u]   <= p_hi[u];
            m_lo[u]   <= p_lo[u];
            m_dz[u]   <= p_dz[u];
            m_done[u] <= 1'b1;
          end
        end else if (start) begin
          if (Signal >= 6'd24 && Signal <= 6'd27) begin
            model_op(w, Signal, dataA, dataB, h, l, z);
            p_hi[u]  <= h;
            p_lo[u]  <= l;
            p_dz[u]  <= z;
            m_dz[u]  <= 1'b0;
            m_rem[u] <= w + 2;
          end else if (Signal == 6'd17) begin
            m_hi[u] <= dataA & mask;
          end else if (Signal == 6'd19) begin
            m_lo[u] <= dataA & mask;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    logic [31:0] eo;
    if (model_ok) begin
      for (int u = 0; u < 2; u++) begin
        eo = (Signal == 6'd16) ? m_hi[u] : (Signal == 6'd18) ? m_lo[u] : 32'd0;
        checkOutput($sformatf("busy u%0d", u), {31'd0, (u == 0) ? busy32 : busy8}, {31'd0, m_rem[u] > 0});
        checkOutput($sformatf("done u%0d", u), {31'd0, (u == 0) ? done32 : done8}, {31'd0, m_done[u]});
        checkOutput($sformatf("div_zero u%0d", u), {31'd0, (u == 0) ? dz32 : dz8}, {31'd0, m_dz[u]});
        checkOutput($sformatf("Output u%0d", u), (u == 0) ? out32 : {24'd0, out8}, eo);
      end
    end
  end

  // Pulse start for one cycle. The task returns 1 ns after the accepting edge.
  task automatic applyStimulus(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    Signal = code; dataA = a; dataB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic readResult(input int unit, input logic [31:0] eh, input logic [31:0] el, input string name);
    Signal = 6'd16; #1;
    checkOutput({name, " HI"}, (unit == 0) ? out32 : {24'd0, out8}, eh);
    Signal = 6'd18; #1;
    checkOutput({name, " LO"}, (unit == 0) ? out32 : {24'd0, out8}, el);
  endtask

  initial begin
    int n;
    logic seen;
    reset = 1'b1; start = 1'b0; Signal = 6'd0; dataA = '0; dataB = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", {31'd0, busy32}, 32'd0);
    checkOutput("reset done", {31'd0, done32}, 32'd0);
    readResult(0, 32'd0, 32'd0, "reset");
    reset = 1'b0;

    $display("[TB] MULTU 0xFFFFFFFF x 0xFFFFFFFF");
    applyStimulus(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0;
    for (int i = 0; i < 40 && busy32; i++) begin
      n++;
      @(posedge clk); #1;
    end
    checkOutput("multu busy cycles", n, 32'd34);
    checkOutput("multu done pulse", {31'd0, done32}, 32'd1);
    readResult(0, 32'hFFFF_FFFE, 32'h0000_0001, "multu max");

    applyStimulus(6'd24, 32'hFFFF_FFFD, 32'd5);
    waitCycles(34);
    readResult(0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult -3x5");

    applyStimulus(6'd24, 32'h8000_0000, 32'h8000_0000);
    waitCycles(34);
    readResult(0, 32'h4000_0000, 32'h0000_0000, "mult min x min");

    applyStimulus(6'd26, 32'hFFFF_FFF9, 32'd2);
    waitCycles(34);
    readResult(0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");

    applyStimulus(6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
    waitCycles(34);
    readResult(0, 32'h0000_0000, 32'h8000_0000, "div overflow");

    applyStimulus(6'd27, 32'd100, 32'd0);
    waitCycles(34);
    checkOutput("divu by zero flag", {31'd0, dz32}, 32'd1);
    checkOutput("divu by zero done", {31'd0, done32}, 32'd1);
    readResult(0, 32'd100, 32'hFFFF_FFFF, "divu by zero");

    applyStimulus(6'd25, 32'd2, 32'd3);
    checkOutput("div_zero cleared on start", {31'd0, dz32}, 32'd0);
    waitCycles(34);
    readResult(0, 32'd0, 32'd6, "multu 2x3");

    $display("[TB] MULTU 6x7 with a DIVU request while busy");
    applyStimulus(6'd25, 32'd6, 32'd7);
    waitCycles(4);
    Signal = 6'd27; dataA = 32'd9; dataB = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    Signal = 6'd18; #1;
    checkOutput("mflo during busy", out32, 32'd6);
    waitCycles(29);
    readResult(0, 32'd0, 32'd42, "multu 6x7 ignore second");

    applyStimulus(6'd17, 32'h0000_1234, 32'd0);
    Signal = 6'd16; #1;
    checkOutput("mthi then mfhi", out32, 32'h0000_1234);
    checkOutput("mthi then mfhi w8", {24'd0, out8}, 32'h0000_0034);

    $display("[TB] reset in the middle of a MULT");
    applyStimulus(6'd24, 32'd5, 32'd7);
    waitCycles(9);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort busy", {31'd0, busy32}, 32'd0);
    readResult(0, 32'd0, 32'd0, "abort");
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done32) seen = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("no done after abort", {31'd0, seen}, 32'd0);

    applyStimulus(6'd25, 32'd200, 32'd200);
    waitCycles(34);
    readResult(1, 32'h0000_009C, 32'h0000_0040, "w8 multu 200x200");
    readResult(0, 32'd0, 32'd40000, "multu 200x200");

    applyStimulus(6'd27, 32'd255, 32'd16);
    waitCycles(34);
    readResult(1, 32'd15, 32'd15, "w8 divu 255/16");
    readResult(0, 32'd15, 32'd15, "divu 255/16");

    waitCycles(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
